// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stage indices,
// mult/div FSM states, stall masks and default latencies.
package pipe_ctrl_pkg;

  localparam int STG_PC    = 0;
  localparam int STG_IFID  = 1;
  localparam int STG_IDEX  = 2;
  localparam int STG_EXMEM = 3;
  localparam int STG_MEMWB = 4;

  localparam int FL_IFID = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MD_BUSY = 2'd1,
    ST_MD_HOLD = 2'd2
  } md_state_t;

  localparam logic [4:0] STALL_DMEM     = 5'b01111;
  localparam logic [4:0] STALL_MD       = 5'b00111;
  localparam logic [4:0] STALL_LOAD_USE = 5'b00011;
  localparam logic [4:0] STALL_HILO     = 5'b00011;
  localparam logic [4:0] STALL_IMEM     = 5'b00001;

  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 32;

endpackage

// File: rtl/md_latency_counter.sv
// 6-bit mult/div latency down-counter: parallel load, saturating decrement,
// terminal-count flag.
module md_latency_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [5:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [5:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != 6'd0)) begin
      r_cnt <= r_cnt - 6'd1;
    end
  end

  assign o_zero = (r_cnt == 6'd0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: combinational stall/flush masks for a 5-stage
// pipeline plus the mult/div occupancy FSM.
//
// state      | meaning
// ST_IDLE    | no mult/div in flight; ex_md_start accepted
// ST_MD_BUSY | counting down the unit latency, EX held while cnt != 0
// ST_MD_HOLD | latency expired during a dmem wait; done deferred until it clears
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_hilo,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       ex_md_start,
  input  logic       ex_md_is_div,
  input  logic       imem_ready,
  input  logic       mem_req,
  input  logic       dmem_ready,
  input  logic       id_branch_taken,
  output logic [4:0] stall,
  output logic [4:0] flush,
  output logic       md_busy,
  output logic       md_done
);

  localparam logic [5:0] MUL_LD = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_LD = 6'(DIV_LAT - 1);

  md_state_t  r_state, w_next;
  logic       w_dmem_wait, w_load_use, w_hilo_use;
  logic       w_md_hold, w_md_done, w_cnt_load, w_cnt_dec, w_cnt_zero;
  logic [5:0] w_cnt_val;
  logic [4:0] w_stall, w_flush;

  assign w_dmem_wait = mem_req & ~dmem_ready;
  assign w_load_use  = ex_mem_read && (ex_rt != 5'd0) &&
                       ((ex_rt == id_rs) || (ex_rt == id_rt));
  assign w_hilo_use  = id_uses_hilo && (r_state != ST_IDLE);
  assign w_cnt_val   = ex_md_is_div ? DIV_LD : MUL_LD;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_md_hold  = 1'b0;
    w_md_done  = 1'b0;
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ex_md_start) begin
          w_md_hold  = 1'b1;
          w_cnt_load = 1'b1;
          w_next     = ST_MD_BUSY;
        end
      end
      ST_MD_BUSY: begin
        w_cnt_dec = 1'b1;
        if (!w_cnt_zero) begin
          w_md_hold = 1'b1;
        end else if (w_dmem_wait) begin
          w_md_hold = 1'b1;
          w_next    = ST_MD_HOLD;
        end else begin
          w_md_done = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      ST_MD_HOLD: begin
        if (w_dmem_wait) begin
          w_md_hold = 1'b1;
        end else begin
          w_md_done = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Masks are contiguous from bit0, so OR-ing them yields the widest one.
  always_comb begin
    w_stall = '0;
    if (!imem_ready)              w_stall = w_stall | STALL_IMEM;
    if (w_load_use)               w_stall = w_stall | STALL_LOAD_USE;
    if (w_hilo_use)               w_stall = w_stall | STALL_HILO;
    if (w_md_hold)                w_stall = w_stall | STALL_MD;
    if (w_dmem_wait)              w_stall = w_stall | STALL_DMEM;
    w_flush          = '0;
    w_flush[FL_IFID] = id_branch_taken & ~w_stall[STG_IFID];
  end

  md_latency_counter u_cnt (
    .clk        (clk),
    .rst_n      (reset),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  assign stall   = reset ? w_stall : '0;
  assign flush   = reset ? w_flush : '0;
  assign md_busy = reset & (r_state != ST_IDLE);
  assign md_done = reset & w_md_done;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// random traffic, compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int MUL_L = 4;
  localparam int DIV_L = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_hilo, ex_mem_read, ex_md_start, ex_md_is_div;
  logic       imem_ready, mem_req, dmem_ready, id_branch_taken;
  logic [4:0] stall, flush;
  logic       md_busy, md_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: an op in flight, cycles since its start, and its latency.
  bit m_active = 0;
  int m_age    = 0;
  int m_lat    = 0;

  pipeline_hazard_ctrl #(.MUL_LAT(MUL_L), .DIV_LAT(DIV_L)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_hilo    (id_uses_hilo),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .ex_md_start     (ex_md_start),
    .ex_md_is_div    (ex_md_is_div),
    .imem_ready      (imem_ready),
    .mem_req         (mem_req),
    .dmem_ready      (dmem_ready),
    .id_branch_taken (id_branch_taken),
    .stall           (stall),
    .flush           (flush),
    .md_busy         (md_busy),
    .md_done         (md_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    id_rs = 0; id_rt = 0; ex_rt = 0; id_uses_hilo = 0; ex_mem_read = 0;
    ex_md_start = 0; ex_md_is_div = 0; imem_ready = 1; mem_req = 0;
    dmem_ready = 1; id_branch_taken = 0;
  endtask

  // One clock: compare outputs to the model at the negedge, advance model at posedge.
  task automatic step(input string tag);
    logic [4:0] e_stall, e_flush;
    logic e_busy, e_done, hold, dwait, lu, hl;
    bit n_active;
    int n_age, n_lat;
    @(negedge clk);
    dwait    = mem_req & ~dmem_ready;
    e_busy   = m_active;
    e_done   = 0;
    hold     = 0;
    n_active = m_active;
    n_age    = m_age + 1;
    n_lat    = m_lat;
    if (!m_active) begin
      if (ex_md_start) begin
        hold = 1; n_active = 1; n_age = 1;
        n_lat = ex_md_is_div ? DIV_L : MUL_L;
      end
    end else if (m_age < m_lat || dwait) begin
      hold = 1;
    end else begin
      e_done = 1; n_active = 0;
    end
    lu = ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
    hl = id_uses_hilo && m_active;
    e_stall = 5'b00000;
    if (!imem_ready) e_stall = 5'b00001;
    if (lu || hl)    e_stall = 5'b00011;
    if (hold)        e_stall = 5'b00111;
    if (dwait)       e_stall = 5'b01111;
    e_flush = {4'b0000, id_branch_taken & ~e_stall[1]};
    if (!reset) begin
      e_stall = 0; e_flush = 0; e_busy = 0; e_done = 0; n_active = 0; n_age = 0;
    end
    check({tag, ".stall"},   {1'b0, stall}, {1'b0, e_stall});
    check({tag, ".flush"},   {1'b0, flush}, {1'b0, e_flush});
    check({tag, ".md_busy"}, {5'b0, md_busy}, {5'b0, e_busy});
    check({tag, ".md_done"}, {5'b0, md_done}, {5'b0, e_done});
    @(posedge clk);
    m_active = n_active; m_age = n_age; m_lat = n_lat;
    #1;
  endtask

  initial begin
    reset = 0;
    quiet();
    for (int i = 0; i < 3; i++) begin
      mem_req = 1; dmem_ready = 0; imem_ready = 0; ex_md_start = 1; id_branch_taken = 1;
      step("rst_hold");
    end
    check("rst.cnt", dut.u_cnt.r_cnt, 6'd0);
    @(posedge clk); #1;
    reset = 1;
    quiet();
    step("idle");

    // Load-use hazard and its r0 exemption
    ex_mem_read = 1; ex_rt = 5; id_rs = 5; id_rt = 7;
    #2; check("lu.stall_lit", {1'b0, stall}, 6'b000011);
    step("load_use");
    ex_rt = 0; id_rs = 0;
    #2; check("lu_r0.stall_lit", {1'b0, stall}, 6'b000000);
    step("load_use_r0");
    quiet();

    // Branch flush, alone and suppressed by a load-use stall
    id_branch_taken = 1;
    #2; check("br.flush_lit", {1'b0, flush}, 6'b000001);
    step("branch");
    ex_mem_read = 1; ex_rt = 9; id_rt = 9;
    step("branch_lu");
    quiet();

    // imem wait alone, then together with dmem wait
    imem_ready = 0;
    step("imem");
    mem_req = 1; dmem_ready = 0;
    #2; check("imem_dmem.stall_lit", {1'b0, stall}, 6'b001111);
    step("imem_dmem");
    quiet();

    // Multiply: hold cycles 1-4, done in 5, busy in 2-5
    for (int c = 1; c <= 7; c++) begin
      quiet();
      ex_md_start = (c == 1);
      #2;
      check($sformatf("mul%0d.stall_lit", c), {1'b0, stall}, (c <= 4) ? 6'b000111 : 6'b000000);
      check($sformatf("mul%0d.done_lit", c), {5'b0, md_done}, {5'b0, c == 5});
      check($sformatf("mul%0d.busy_lit", c), {5'b0, md_busy}, {5'b0, c >= 2 && c <= 5});
      step($sformatf("mul%0d", c));
    end

    // Divide with mfhi in ID and dmem wait in cycles 30-35
    for (int c = 1; c <= 38; c++) begin
      quiet();
      ex_md_start  = (c == 1);
      ex_md_is_div = 1;
      id_uses_hilo = 1;
      mem_req      = (c >= 30 && c <= 35);
      dmem_ready   = !(c >= 30 && c <= 35);
      #2;
      check($sformatf("div%0d.done_lit", c), {5'b0, md_done}, {5'b0, c == 36});
      step($sformatf("div%0d", c));
    end

    // Divide abandoned by reset at cycle 10
    for (int c = 1; c <= 20; c++) begin
      quiet();
      ex_md_start  = (c == 1);
      ex_md_is_div = 1;
      reset        = !(c == 10 || c == 11);
      if (c == 10) begin
        mem_req = 1; dmem_ready = 0; imem_ready = 0;
      end
      step($sformatf("divrst%0d", c));
      if (c == 12) begin
        check("divrst.cnt", dut.u_cnt.r_cnt, 6'd0);
      end
    end
    reset = 1;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      reset           = ($urandom_range(0, 79) != 0);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rt           = 5'($urandom_range(0, 3));
      ex_mem_read     = ($urandom_range(0, 2) == 0);
      id_uses_hilo    = ($urandom_range(0, 3) == 0);
      ex_md_start     = ($urandom_range(0, 5) == 0);
      ex_md_is_div    = ($urandom_range(0, 3) == 0);
      imem_ready      = ($urandom_range(0, 4) != 0);
      mem_req         = ($urandom_range(0, 2) == 0);
      dmem_ready      = ($urandom_range(0, 1) == 0);
      id_branch_taken = ($urandom_range(0, 3) == 0);
      step($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
